// File: rtl/message_loader.sv
// message_loader: builds a hex message one nibble at a time from switches and
// three push buttons, then offers the completed message to a hash engine with
// a valid/ready handshake. Buttons are synchronized and debounced before use.
module message_loader #(
    parameter int MSG_BITS  = 120,
    parameter int DB_CYCLES = 1250000
) (
    input  logic                               sysclk_125mhz,
    input  logic                               rst,
    input  logic [3:0]                         nibble_in,
    input  logic                               btn_enter,
    input  logic                               btn_back,
    input  logic                               btn_go,
    input  logic                               hash_ready,
    output logic [MSG_BITS-1:0]                message,
    output logic                               msg_valid,
    output logic [$clog2(MSG_BITS/4+1)-1:0]    nibble_count,
    output logic                               full,
    output logic [15:0]                        preview
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int NIBBLES = MSG_BITS / 4;
    localparam int NIB_W   = $clog2(NIBBLES + 1);
    localparam int CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam int NUM_BTN = 3;

    // Button index map into the packed button vectors.
    localparam int BTN_ENTER = 0;
    localparam int BTN_BACK  = 1;
    localparam int BTN_GO    = 2;

    // Counter value on which the debounce window completes.
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    // Nibble count just before the message becomes full.
    localparam logic [NIB_W-1:0] LAST_SLOT = NIB_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SEND  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Nibble synchronizer
    // ------------------------------------------------------------------
    logic [3:0] nib_s1_q, nib_s1_d;
    logic [3:0] nib_s2_q, nib_s2_d;

    // Next values for the two-stage nibble synchronizer.
    always_comb begin
        nib_s1_d = nibble_in;
        nib_s2_d = nib_s1_q;
    end

    // Nibble synchronizer flops; the second stage is the only copy used.
    always_ff @(posedge sysclk_125mhz or posedge rst) begin
        if (rst) begin
            nib_s1_q <= '0;
            nib_s2_q <= '0;
        end else begin
            nib_s1_q <= nib_s1_d;
            nib_s2_q <= nib_s2_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-button synchronizer, debouncer and press detector
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press_pulse;

    assign btn_raw = {btn_go, btn_back, btn_enter};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic             s1_q, s1_d;
            logic             s2_q, s2_d;
            logic             db_q, db_d;
            logic             prev_q, prev_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Debounce: the stable level follows the synchronized level only
            // after DB_CYCLES consecutive cycles of disagreement; any agreement
            // in between restarts the window.
            always_comb begin
                s1_d   = btn_raw[gi];
                s2_d   = s1_q;
                db_d   = db_q;
                cnt_d  = '0;
                prev_d = db_q;
                if (s2_q != db_q) begin
                    if (cnt_q == DB_LAST) begin
                        db_d  = s2_q;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Button state flops, all cleared by reset so a held button must
            // serve a fresh debounce window after reset release.
            always_ff @(posedge sysclk_125mhz or posedge rst) begin
                if (rst) begin
                    s1_q   <= 1'b0;
                    s2_q   <= 1'b0;
                    db_q   <= 1'b0;
                    prev_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    s1_q   <= s1_d;
                    s2_q   <= s2_d;
                    db_q   <= db_d;
                    prev_q <= prev_d;
                    cnt_q  <= cnt_d;
                end
            end

            // One-cycle pulse on each debounced rising edge.
            assign press_pulse[gi] = db_q & ~prev_q;
        end
    endgenerate

    logic enter_pulse;
    logic back_pulse;
    logic go_pulse;

    assign enter_pulse = press_pulse[BTN_ENTER];
    assign back_pulse  = press_pulse[BTN_BACK];
    assign go_pulse    = press_pulse[BTN_GO];

    // ------------------------------------------------------------------
    // Control FSM and message datapath
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [MSG_BITS-1:0] message_q, message_d;
    logic [NIB_W-1:0]    count_q, count_d;

    // State register together with the message and nibble counter.
    always_ff @(posedge sysclk_125mhz or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ENTRY;
            message_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            message_q <= message_d;
            count_q   <= count_d;
        end
    end

    // Next state and datapath update; back outranks go, go outranks enter,
    // and only the highest-priority pulse in a cycle is allowed to act.
    always_comb begin
        state_d   = state_q;
        message_d = message_q;
        count_d   = count_q;
        case (state_q)
            ST_ENTRY: begin
                if (back_pulse) begin
                    if (count_q != '0) begin
                        message_d = message_q >> 4;
                        count_d   = count_q - 1'b1;
                    end
                end else if (enter_pulse && !go_pulse) begin
                    // Go has nothing to do on a partial message but still
                    // masks a coincident enter.
                    message_d = {message_q[MSG_BITS-5:0], nib_s2_q};
                    count_d   = count_q + 1'b1;
                    if (count_q == LAST_SLOT) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (back_pulse) begin
                    message_d = message_q >> 4;
                    count_d   = count_q - 1'b1;
                    state_d   = ST_ENTRY;
                end else if (go_pulse) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // msg_valid is high throughout SEND, so ready alone completes
                // the handshake; all buttons are ignored here.
                if (hash_ready) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (back_pulse) begin
                    message_d = '0;
                    count_d   = '0;
                    state_d   = ST_ENTRY;
                end
            end
            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

    // Status outputs decoded from the registered state only.
    always_comb begin
        msg_valid = (state_q == ST_SEND);
        full      = (state_q != ST_ENTRY);
    end

    assign message      = message_q;
    assign nibble_count = count_q;
    assign preview      = message_q[15:0];

endmodule

// File: tb/tb_message_loader.sv
// Directed testbench for message_loader with a short debounce window.
module tb_message_loader;

    localparam int MSG_BITS  = 120;
    localparam int DB_CYCLES = 4;
    localparam int NIB_W     = $clog2(MSG_BITS/4 + 1);

    logic                clk;
    logic                rst;
    logic [3:0]          nibble_in;
    logic                btn_enter;
    logic                btn_back;
    logic                btn_go;
    logic                hash_ready;
    logic [MSG_BITS-1:0] message;
    logic                msg_valid;
    logic [NIB_W-1:0]    nibble_count;
    logic                full;
    logic [15:0]         preview;

    int n_evals = 0;
    int n_fails = 0;

    localparam logic [MSG_BITS-1:0] MSG_FULL  = 120'h48656c6c6f2c205348412d32353621;
    localparam logic [MSG_BITS-1:0] MSG_BACK1 = 120'h048656c6c6f2c205348412d3235362;

    message_loader #(
        .MSG_BITS (MSG_BITS),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .sysclk_125mhz(clk),
        .rst          (rst),
        .nibble_in    (nibble_in),
        .btn_enter    (btn_enter),
        .btn_back     (btn_back),
        .btn_go       (btn_go),
        .hash_ready   (hash_ready),
        .message      (message),
        .msg_valid    (msg_valid),
        .nibble_count (nibble_count),
        .full         (full),
        .preview      (preview)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_evals++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a button set high for 10 cycles, low for 10, then sample point.
    // sel: 0 enter, 1 back, 2 go, 3 back+go, 4 enter+go
    task automatic press(input int sel);
        btn_enter = (sel == 0) || (sel == 4);
        btn_back  = (sel == 1) || (sel == 3);
        btn_go    = (sel == 2) || (sel == 3) || (sel == 4);
        repeat (10) @(posedge clk);
        btn_enter = 1'b0;
        btn_back  = 1'b0;
        btn_go    = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("press sel=%0d -> count=%0d full=%0b valid=%0b preview=%h",
                 sel, nibble_count, full, msg_valid, preview);
    endtask

    task automatic enter_nibble(input logic [3:0] nib);
        nibble_in = nib;
        press(0);
    endtask

    task automatic enter_full_msg();
        logic [MSG_BITS-1:0] m;
        m = MSG_FULL;
        for (int i = MSG_BITS/4 - 1; i >= 0; i--) begin
            enter_nibble(m[i*4 +: 4]);
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !msg_valid; i++) @(negedge clk);
        chk("valid_rise", {127'd0, msg_valid}, 128'd1);
    endtask

    initial begin
        rst = 1'b1;
        nibble_in = 4'h0;
        btn_enter = 1'b0;
        btn_back = 1'b0;
        btn_go = 1'b0;
        hash_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_message", message, 128'd0);
        chk("rst_count", nibble_count, 128'd0);
        chk("rst_full", full, 128'd0);
        chk("rst_valid", msg_valid, 128'd0);
        chk("rst_preview", preview, 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Enter A, B, then back three times.
        enter_nibble(4'hA);
        chk("ent_A_msg", message, 128'hA);
        chk("ent_A_cnt", nibble_count, 128'd1);
        enter_nibble(4'hB);
        chk("ent_B_msg", message, 128'hAB);
        chk("ent_B_cnt", nibble_count, 128'd2);
        press(1);
        chk("back1_msg", message, 128'hA);
        chk("back1_cnt", nibble_count, 128'd1);
        press(1);
        chk("back2_msg", message, 128'h0);
        chk("back2_cnt", nibble_count, 128'd0);
        press(1);
        chk("back3_msg", message, 128'h0);
        chk("back3_cnt", nibble_count, 128'd0);
        chk("back3_full", full, 128'd0);

        // Bounce: short glitches must not append; the final stable press must.
        nibble_in = 4'h5;
        for (int k = 0; k < 2; k++) begin
            btn_enter = 1'b1;
            repeat (2) @(posedge clk);
            btn_enter = 1'b0;
            repeat (2) @(posedge clk);
        end
        @(negedge clk);
        chk("bounce_glitch_cnt", nibble_count, 128'd0);
        press(0);
        chk("bounce_cnt", nibble_count, 128'd1);
        chk("bounce_msg", message, 128'h5);
        press(1);
        chk("bounce_clr_cnt", nibble_count, 128'd0);

        // Full 30-nibble message.
        enter_full_msg();
        chk("full_msg", message, MSG_FULL);
        chk("full_cnt", nibble_count, 128'd30);
        chk("full_flag", full, 128'd1);
        chk("full_preview", preview, 128'h3621);
        chk("full_valid", msg_valid, 128'd0);

        // Enter is ignored while full.
        enter_nibble(4'hF);
        chk("full_enter_msg", message, MSG_FULL);
        chk("full_enter_cnt", nibble_count, 128'd30);

        // Back and go together: back wins.
        press(3);
        chk("coinc_cnt", nibble_count, 128'd29);
        chk("coinc_msg", message, MSG_BACK1);
        chk("coinc_preview", preview, 128'h5362);
        chk("coinc_full", full, 128'd0);
        chk("coinc_valid", msg_valid, 128'd0);

        // Refill the last nibble.
        enter_nibble(4'h1);
        chk("refill_msg", message, MSG_FULL);
        chk("refill_full", full, 128'd1);

        // Go with hash_ready held low for 20 valid cycles; back press ignored.
        btn_go = 1'b1;
        wait_valid();
        btn_go = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) btn_back = 1'b1;
            if (i == 8) btn_back = 1'b0;
            chk("send_valid", msg_valid, 128'd1);
            chk("send_msg", message, MSG_FULL);
            @(negedge clk);
        end
        hash_ready = 1'b1;
        chk("hs_valid", msg_valid, 128'd1);
        @(negedge clk);
        hash_ready = 1'b0;
        $display("handshake done: valid=%0b full=%0b", msg_valid, full);
        chk("hold_valid", msg_valid, 128'd0);
        chk("hold_full", full, 128'd1);
        chk("hold_msg", message, MSG_FULL);
        chk("hold_cnt", nibble_count, 128'd30);

        // In HOLD, enter and go are ignored.
        nibble_in = 4'h9;
        press(4);
        chk("hold_eg_msg", message, MSG_FULL);
        chk("hold_eg_valid", msg_valid, 128'd0);
        chk("hold_eg_full", full, 128'd1);

        // Back in HOLD clears everything.
        press(1);
        chk("hold_back_msg", message, 128'd0);
        chk("hold_back_cnt", nibble_count, 128'd0);
        chk("hold_back_full", full, 128'd0);

        // Reset mid-SEND, with enter held through reset release.
        enter_full_msg();
        btn_go = 1'b1;
        wait_valid();
        @(negedge clk);
        #1;
        rst = 1'b1;
        btn_go = 1'b0;
        btn_enter = 1'b1;
        nibble_in = 4'h7;
        #1;
        $display("reset mid-send: valid=%0b count=%0d", msg_valid, nibble_count);
        chk("rstsend_valid", msg_valid, 128'd0);
        chk("rstsend_msg", message, 128'd0);
        chk("rstsend_cnt", nibble_count, 128'd0);
        chk("rstsend_full", full, 128'd0);
        chk("rstsend_preview", preview, 128'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_early_cnt", nibble_count, 128'd0);
        repeat (8) @(negedge clk);
        chk("held_late_cnt", nibble_count, 128'd1);
        chk("held_late_msg", message, 128'h7);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_evals, n_fails);
        $finish;
    end

endmodule
